// File: rtl/normalizador_pf.sv
// Normalize-and-round stage after the FP adder. One operand is in flight at a time,
// with one left shift per cycle, round-to-nearest-even, and an IEEE-754 single-precision pack.
module normalizador_pf (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [26:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow
);

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

  state_t      state;
  logic        sgnWork;
  logic [8:0]  expWork;
  logic [26:0] mantWork;

  logic [24:0] m24;
  logic [8:0]  expRnd;
  logic [22:0] fracRnd;

  // Round-to-nearest-even on {hidden,fraction} with guard/sticky below.
  // Bit 24 of the returned sum is the mantissa carry-out.
  function automatic logic [24:0] roundNearestEven(input logic [26:0] m);
    logic roundUp;
    roundUp = m[1] & (m[0] | m[2]);
    return {1'b0, m[25:2]} + {24'd0, roundUp};
  endfunction

  always_comb begin
    m24     = roundNearestEven(mantWork);
    expRnd  = expWork;
    fracRnd = m24[22:0];
    if (m24[24]) begin
      expRnd  = expWork + 9'd1;
      fracRnd = m24[23:1];
    end
  end

  // Working operand registers: data only, no reset.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (in_valid) begin
        sgnWork  <= in_sign;
        expWork  <= {1'b0, in_exp};
        mantWork <= in_mant;
      end
      SHIFT: if (expWork != 9'h0FF && mantWork != 27'd0) begin
        if (mantWork[26]) begin
          mantWork <= {1'b0, mantWork[26:2], mantWork[1] | mantWork[0]};
          expWork  <= expWork + 9'd1;
        end else if (!mantWork[25] && expWork > 9'd1) begin
          mantWork <= {mantWork[25:0], 1'b0};
          expWork  <= expWork - 9'd1;
        end
      end
      default: ;
    endcase
  end

  // Control FSM and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= 32'h0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          state     <= SHIFT;
          in_ready  <= 1'b0;
          overflow  <= 1'b0;
          underflow <= 1'b0;
        end
        SHIFT: begin
          if (expWork == 9'h0FF) begin
            result    <= {sgnWork, 8'hFF, mantWork[24:2]};
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (mantWork == 27'd0) begin
            result    <= {sgnWork, 31'd0};
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (mantWork[26]) begin
            state <= ROUND;
          end else if (!mantWork[25] && expWork > 9'd1) begin
            state <= SHIFT;
          end else if (!mantWork[25]) begin
            // Exponent exhausted before the hidden bit surfaced.
            result    <= {sgnWork, 31'd0};
            underflow <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          if (expRnd >= 9'h0FF) begin
            result   <= {sgnWork, 8'hFF, 23'd0};
            overflow <= 1'b1;
          end else begin
            result <= {sgnWork, expRnd[7:0], fracRnd};
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_normalizador_pf.sv
// Directed bench for normalizador_pf: a reference model derives result/flags/latency
// for each operand, and literal expectations pin that model.
module tb_normalizador_pf;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sign;
  logic [7:0]  in_exp;
  logic [26:0] in_mant;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic        overflow, underflow;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    int          lat;
  } expect_t;

  expect_t expd;
  bit      busy = 1'b0;
  int      edges = 0;

  normalizador_pf dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // Value-level model: normalize by counting leading zeros, then round with integer arithmetic.
  function automatic expect_t model(input logic s, input logic [7:0] e, input logic [26:0] m);
    expect_t x;
    int ex, n, pos, avail;
    logic [26:0] mm;
    logic [24:0] sig;
    x.ovf = 1'b0; x.unf = 1'b0; x.res = '0; x.lat = 1;
    mm = m; ex = int'(e);
    if (e == 8'hFF) begin x.res = {s, 8'hFF, m[24:2]}; return x; end
    if (m == 27'd0) begin x.res = {s, 31'd0}; return x; end
    if (mm[26]) begin
      mm = (mm >> 1) | (mm & 27'd1);
      ex = ex + 1;
      x.lat = 2;
    end else begin
      pos = 0;
      for (int i = 0; i < 26; i++) if (mm[i]) pos = i;
      n = 25 - pos;
      avail = (ex > 1) ? ex - 1 : 0;
      if (n > avail) begin
        x.res = {s, 31'd0}; x.unf = 1'b1; x.lat = 1 + avail;
        return x;
      end
      mm = mm << n;
      ex = ex - n;
      x.lat = 2 + n;
    end
    sig = {1'b0, mm[25:2]};
    if (mm[1] && (mm[0] || mm[2])) sig = sig + 25'd1;
    if (sig[24]) begin sig = sig >> 1; ex = ex + 1; end
    if (ex >= 255) begin
      x.res = {s, 8'hFF, 23'd0}; x.ovf = 1'b1;
    end else begin
      x.res = {s, ex[7:0], sig[22:0]};
    end
    return x;
  endfunction

  // Track capture and handshake edges; load the model on capture.
  always @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
    end else if (busy) begin
      if (out_valid && out_ready) busy <= 1'b0;
      else edges <= edges + 1;
    end else if (in_valid && in_ready) begin
      busy  <= 1'b1;
      edges <= 0;
      expd  <= model(in_sign, in_exp, in_mant);
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) begin
        chk("inReadyBusy", {31'd0, in_ready}, 32'd0);
        chk("outValidTiming", {31'd0, out_valid}, {31'd0, edges >= expd.lat});
        if (edges >= expd.lat) begin
          chk("modelResult", result, expd.res);
          chk("modelOverflow", {31'd0, overflow}, {31'd0, expd.ovf});
          chk("modelUnderflow", {31'd0, underflow}, {31'd0, expd.unf});
        end
      end else begin
        chk("inReadyIdle", {31'd0, in_ready}, 32'd1);
        chk("outValidIdle", {31'd0, out_valid}, 32'd0);
      end
    end
  end

  task automatic sendOp(input logic s, input logic [7:0] e, input logic [26:0] m, input int hold,
                        output logic [31:0] r, output logic ov, output logic un, output int lat);
    in_sign = s; in_exp = e; in_mant = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      checks++; failures++;
      $display("FAIL timeout: out_valid still 0 after %0d cycles", lat);
    end
    r = result; ov = overflow; un = underflow;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'h10; in_mant = 27'h4000000;
      @(posedge clk); #1;
      chk("holdInReady", {31'd0, in_ready}, 32'd0);
      chk("holdOutValid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic runCase(input string nm, input logic s, input logic [7:0] e, input logic [26:0] m,
                         input int hold, input logic [31:0] wantRes, input logic wantOv,
                         input logic wantUn, input int wantLat);
    logic [31:0] r;
    logic ov, un;
    int lat;
    sendOp(s, e, m, hold, r, ov, un, lat);
    chk({nm, "_result"}, r, wantRes);
    chk({nm, "_ovf"}, {31'd0, ov}, {31'd0, wantOv});
    chk({nm, "_unf"}, {31'd0, un}, {31'd0, wantUn});
    chk({nm, "_lat"}, lat, wantLat);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = 8'h0; in_mant = 27'h0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rstResult", result, 32'h0);
    chk("rstInReady", {31'd0, in_ready}, 32'd1);
    chk("rstOutValid", {31'd0, out_valid}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    runCase("plain",     1'b0, 8'h7F, 27'h2000000, 0, 32'h3F800000, 1'b0, 1'b0, 2);
    runCase("carry",     1'b0, 8'h7F, 27'h4000000, 0, 32'h40000000, 1'b0, 1'b0, 2);
    runCase("leftNorm",  1'b0, 8'h80, 27'h0800000, 0, 32'h3F000000, 1'b0, 1'b0, 4);
    runCase("roundUp",   1'b0, 8'h7F, 27'h3FFFFFE, 0, 32'h40000000, 1'b0, 1'b0, 2);
    runCase("tieEven",   1'b0, 8'h7F, 27'h3FFFFFA, 0, 32'h3FFFFFFE, 1'b0, 1'b0, 2);
    runCase("carryRnd",  1'b0, 8'h80, 27'h4000006, 0, 32'h40800001, 1'b0, 1'b0, 2);
    runCase("overflow",  1'b0, 8'hFE, 27'h4000000, 0, 32'h7F800000, 1'b1, 1'b0, 2);
    runCase("underflow", 1'b1, 8'h01, 27'h1000000, 0, 32'h80000000, 1'b0, 1'b1, 1);
    runCase("flushLate", 1'b0, 8'h03, 27'h0400000, 0, 32'h00000000, 1'b0, 1'b1, 3);
    runCase("zero",      1'b1, 8'h55, 27'h0000000, 0, 32'h80000000, 1'b0, 1'b0, 1);
    runCase("passFF",    1'b0, 8'hFF, 27'h000000C, 0, 32'h7F800003, 1'b0, 1'b0, 1);
    runCase("holdReady", 1'b0, 8'h7F, 27'h2000000, 5, 32'h3F800000, 1'b0, 1'b0, 2);

    // Reset in the middle of a long left-shift run.
    in_sign = 1'b0; in_exp = 8'h80; in_mant = 27'h0000100; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("midRstResult", result, 32'h0);
    chk("midRstOutValid", {31'd0, out_valid}, 32'd0);
    chk("midRstInReady", {31'd0, in_ready}, 32'd1);
    chk("midRstFlags", {30'd0, overflow, underflow}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    runCase("afterRst",  1'b0, 8'h7F, 27'h2000000, 0, 32'h3F800000, 1'b0, 1'b0, 2);
    runCase("longShift", 1'b0, 8'h80, 27'h0000100, 0, 32'h37800000, 1'b0, 1'b0, 19);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
